// File: rtl/ppg_beat_detector.sv
// rtl/ppg_beat_detector.sv - PPG sample reader, moving-average filter and beat/IBI detector
//
// Purpose:
//   Pops PPG samples from an upstream FIFO (one sample every two cycles at most).
//   Each sample is smoothed by a 2**AVG_LOG2-tap moving average. Heartbeats are
//   detected by a threshold crossing with hysteresis and a refractory window.
//   The interval between beats, in samples, is reported on ibi.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   empty      in   FIFO empty flag
//   Data_out   in   FIFO read data, valid the cycle after rd_en
//   rd_en      out  FIFO pop request (single-cycle, never while empty)
//   thr_hi     in   rising (beat) threshold, compared with >=
//   thr_lo     in   re-arm threshold, compared with strict <
//   filt       out  moving-average value
//   filt_valid out  one-cycle strobe when filt updates
//   beat_pulse out  one-cycle strobe on a detected beat
//   ibi        out  last inter-beat interval in samples (held between beats)
//   ibi_valid  out  one-cycle strobe with beat_pulse when ibi is meaningful

module ppg_beat_detector #(
  parameter int WIDTH     = 10,
  parameter int AVG_LOG2  = 2,
  parameter int IBI_WIDTH = 12,
  parameter int REFRACT   = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty,
  input  logic [WIDTH-1:0]     Data_out,
  output logic                 rd_en,
  input  logic [WIDTH-1:0]     thr_hi,
  input  logic [WIDTH-1:0]     thr_lo,
  output logic [WIDTH-1:0]     filt,
  output logic                 filt_valid,
  output logic                 beat_pulse,
  output logic [IBI_WIDTH-1:0] ibi,
  output logic                 ibi_valid
);

  localparam int TAPS  = 1 << AVG_LOG2;
  localparam int SUM_W = WIDTH + AVG_LOG2;

  localparam logic [IBI_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [IBI_WIDTH-1:0] REFRACT_C = IBI_WIDTH'(REFRACT);

  typedef enum logic {RD_IDLE, RD_CAPT} rd_state_e;
  typedef enum logic {DET_BELOW, DET_ABOVE} det_state_e;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e rd_state_q, rd_state_d;
  logic      capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  // rd_en is a Mealy output so the FIFO word lands exactly in the CAPT cycle.
  // It is gated by reset so no pop is requested while the pipeline is held.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_en      = 1'b0;
    capture    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (!empty) begin
          rd_en      = !reset;
          rd_state_d = RD_CAPT;
        end
      end
      RD_CAPT: begin
        capture    = 1'b1;
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1: moving average
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] taps_q [TAPS];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic             filt_valid_q;

  // The running sum holds at most TAPS full-scale samples, so SUM_W bits
  // cannot overflow and the subtraction never goes negative.
  always_comb begin
    sum_d  = sum_q - SUM_W'(taps_q[TAPS-1]) + SUM_W'(Data_out);
    filt_d = sum_d[SUM_W-1:AVG_LOG2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q        <= '0;
      filt_q       <= '0;
      filt_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        taps_q[i] <= '0;
      end
    end else begin
      filt_valid_q <= capture;
      if (capture) begin
        sum_q     <= sum_d;
        filt_q    <= filt_d;
        taps_q[0] <= Data_out;
        for (int i = 1; i < TAPS; i++) begin
          taps_q[i] <= taps_q[i-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: beat detection
  // ---------------------------------------------------------------------------
  det_state_e           det_q, det_d;
  logic [IBI_WIDTH-1:0] cnt_q, cnt_d, cnt_next;
  logic                 cnt_sat;
  logic                 have_prev_q, have_prev_d;
  logic [IBI_WIDTH-1:0] ibi_q, ibi_d;
  logic                 beat_q, beat_d;
  logic                 ibi_valid_q, ibi_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      det_q       <= DET_BELOW;
      cnt_q       <= '0;
      have_prev_q <= 1'b0;
      ibi_q       <= '0;
      beat_q      <= 1'b0;
      ibi_valid_q <= 1'b0;
    end else begin
      det_q       <= det_d;
      cnt_q       <= cnt_d;
      have_prev_q <= have_prev_d;
      ibi_q       <= ibi_d;
      beat_q      <= beat_d;
      ibi_valid_q <= ibi_valid_d;
    end
  end

  always_comb begin
    // Sample counter saturates; a saturated interval is reported but flagged invalid.
    cnt_next    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + IBI_WIDTH'(1);
    cnt_sat     = (cnt_next == CNT_MAX);
    det_d       = det_q;
    cnt_d       = cnt_q;
    have_prev_d = have_prev_q;
    ibi_d       = ibi_q;
    beat_d      = 1'b0;
    ibi_valid_d = 1'b0;
    if (filt_valid_q) begin
      cnt_d = cnt_next;
      case (det_q)
        DET_BELOW: begin
          if (filt_q >= thr_hi) begin
            // Crossing inside the refractory window still arms ABOVE so the
            // same excursion cannot produce a late beat once the window ends.
            det_d = DET_ABOVE;
            if ((cnt_next > REFRACT_C) || !have_prev_q) begin
              beat_d      = 1'b1;
              ibi_d       = cnt_next;
              ibi_valid_d = have_prev_q && !cnt_sat;
              have_prev_d = 1'b1;
              cnt_d       = '0;
            end
          end
        end
        DET_ABOVE: begin
          if (filt_q < thr_lo) begin
            det_d = DET_BELOW;
          end
        end
        default: det_d = DET_BELOW;
      endcase
    end
  end

  assign filt       = filt_q;
  assign filt_valid = filt_valid_q;
  assign beat_pulse = beat_q;
  assign ibi        = ibi_q;
  assign ibi_valid  = ibi_valid_q;

endmodule

// File: tb/tb_ppg_beat_detector.sv
// tb/tb_ppg_beat_detector.sv - self-checking bench for ppg_beat_detector

module tb_ppg_beat_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty;
  logic [9:0]  Data_out;
  logic        rd_en;
  logic [9:0]  thr_hi;
  logic [9:0]  thr_lo;
  logic [9:0]  filt;
  logic        filt_valid;
  logic        beat_pulse;
  logic [11:0] ibi;
  logic        ibi_valid;

  always #5 clk = ~clk;

  ppg_beat_detector dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .Data_out   (Data_out),
    .rd_en      (rd_en),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .filt       (filt),
    .filt_valid (filt_valid),
    .beat_pulse (beat_pulse),
    .ibi        (ibi),
    .ibi_valid  (ibi_valid)
  );

  typedef struct {
    int filt;
    bit beat;
    int ibi;
    bit iv;
  } exp_t;

  typedef struct {
    int sample;
    int filt;
    bit beat;
    int ibi;
    bit iv;
  } vec_t;

  typedef struct {
    int ibi;
    bit iv;
  } beat_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  exp_q[$];
  int    fifo_q[$];
  beat_t beat_log[$];
  int    filt_log[$];

  // reference model state
  int m_taps[4];
  int m_sum;
  int m_cnt;
  bit m_have;
  bit m_above;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_taps[i] = 0;
    m_sum   = 0;
    m_cnt   = 0;
    m_have  = 0;
    m_above = 0;
  endtask

  task automatic model_step(input int s, output exp_t e);
    int cn;
    m_sum = m_sum - m_taps[3] + s;
    for (int i = 3; i > 0; i--) m_taps[i] = m_taps[i-1];
    m_taps[0] = s;
    e.filt = m_sum / 4;
    e.beat = 0;
    e.ibi  = 0;
    e.iv   = 0;
    cn = (m_cnt >= 4095) ? 4095 : m_cnt + 1;
    if (!m_above) begin
      if (e.filt >= 600) begin
        m_above = 1;
        if (cn > 50 || !m_have) begin
          e.beat = 1;
          e.ibi  = cn;
          e.iv   = m_have && (cn != 4095);
          m_have = 1;
          m_cnt  = 0;
        end else begin
          m_cnt = cn;
        end
      end else begin
        m_cnt = cn;
      end
    end else begin
      if (e.filt < 400) m_above = 0;
      m_cnt = cn;
    end
  endtask

  task automatic send(input int s);
    exp_t e;
    model_step(s, e);
    exp_q.push_back(e);
    fifo_q.push_back(s);
  endtask

  task automatic send_n(input int s, input int n);
    for (int i = 0; i < n; i++) send(s);
  endtask

  task automatic send_tab(input vec_t v);
    exp_t e;
    exp_t dummy;
    model_step(v.sample, dummy);
    e.filt = v.filt;
    e.beat = v.beat;
    e.ibi  = v.ibi;
    e.iv   = v.iv;
    exp_q.push_back(e);
    fifo_q.push_back(v.sample);
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail_now({name, "_timeout"});
    repeat (4) @(negedge clk);
  endtask

  // FIFO model: registered read, data valid the cycle after rd_en
  initial begin
    bit pop;
    Data_out = '0;
    empty    = 1'b1;
    forever begin
      @(negedge clk);
      pop = rd_en;
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) Data_out = 10'(fifo_q.pop_front());
      empty = (fifo_q.size() == 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   r;
    bit   pend;
    bit   prev_rd;
    bit   prev_empty;
    bit   prev_r;
    exp_t pe;
    exp_t e;
    beat_t b;
    pend       = 0;
    prev_rd    = 0;
    prev_empty = 1;
    prev_r     = 1;
    forever begin
      @(posedge clk);
      r = reset;
      @(negedge clk);
      if (r) begin
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_filt", int'(filt), 0);
        chk("rst_filt_valid", int'(filt_valid), 0);
        chk("rst_beat_pulse", int'(beat_pulse), 0);
        chk("rst_ibi", int'(ibi), 0);
        chk("rst_ibi_valid", int'(ibi_valid), 0);
        exp_q.delete();
        beat_log.delete();
        filt_log.delete();
        pend = 0;
      end else begin
        if (pend) begin
          chk("beat_pulse", int'(beat_pulse), int'(pe.beat));
          if (pe.beat) begin
            chk("ibi", int'(ibi), pe.ibi);
            chk("ibi_valid", int'(ibi_valid), int'(pe.iv));
            b.ibi = int'(ibi);
            b.iv  = ibi_valid;
            beat_log.push_back(b);
          end else begin
            chk("ibi_valid_idle", int'(ibi_valid), 0);
          end
          pend = 0;
        end else begin
          chk("no_strobe", int'({beat_pulse, ibi_valid}), 0);
        end
        if (filt_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("stray_filt_valid");
          end else begin
            e = exp_q.pop_front();
            chk("filt", int'(filt), e.filt);
            filt_log.push_back(int'(filt));
            pe   = e;
            pend = 1;
          end
        end
        n_tests++;
        if ((rd_en && empty) || (rd_en && prev_rd) ||
            (!rd_en && !empty && !prev_rd && !prev_empty && !prev_r)) begin
          n_fail++;
          $display("FAIL rd_en_protocol: rd_en=%0b empty=%0b prev_rd=%0b prev_empty=%0b",
                   rd_en, empty, prev_rd, prev_empty);
        end
      end
      prev_rd    = rd_en;
      prev_empty = empty;
      prev_r     = r;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    vec_t tab[6];
    int   n0;
    int   k;
    tab[0] = '{800, 200, 0, 0, 0};
    tab[1] = '{800, 400, 0, 0, 0};
    tab[2] = '{800, 600, 1, 3, 0};
    tab[3] = '{800, 800, 0, 0, 0};
    tab[4] = '{800, 800, 0, 0, 0};
    tab[5] = '{800, 800, 0, 0, 0};

    reset  = 1'b1;
    thr_hi = 10'd600;
    thr_lo = 10'd400;
    model_reset();
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // constant 800: ramp, first beat, single beat while high
    for (int i = 0; i < 6; i++) send_tab(tab[i]);
    drain(200, "const");
    chk("const_beats", beat_log.size(), 1);

    // periodic input, period 100 samples
    send_n(0, 90);
    for (int p = 0; p < 3; p++) begin
      send_n(800, 10);
      send_n(0, 90);
    end
    drain(2000, "periodic");
    if (beat_log.size() > 0) begin
      chk("periodic_last_ibi", beat_log[beat_log.size()-1].ibi, 100);
      chk("periodic_last_iv", int'(beat_log[beat_log.size()-1].iv), 1);
    end else begin
      fail_now("periodic_no_beats");
    end
    chk("ibi_hold", int'(ibi), 100);

    // glitch inside refractory window
    n0 = beat_log.size();
    send_n(800, 10);
    send_n(0, 22);
    send_n(800, 8);
    send_n(0, 60);
    send_n(800, 10);
    send_n(0, 90);
    drain(2000, "glitch");
    chk("glitch_beats", beat_log.size() - n0, 2);
    if (beat_log.size() > 0) begin
      chk("glitch_ibi", beat_log[beat_log.size()-1].ibi, 100);
    end

    // reset asserted in the CAPT cycle of a running periodic stream
    for (int p = 0; p < 3; p++) begin
      send_n(800, 10);
      send_n(0, 90);
    end
    k = 0;
    while (fifo_q.size() > 150 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) fail_now("midrst_wait_timeout");
    k = 0;
    @(negedge clk);
    while (!rd_en && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_now("midrst_rd_en_timeout");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    fifo_q.delete();
    empty = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    send_n(800, 10);
    send_n(0, 90);
    send_n(800, 10);
    send_n(0, 90);
    drain(2000, "midrst");
    if (filt_log.size() >= 3) begin
      chk("midrst_ramp0", filt_log[0], 200);
      chk("midrst_ramp1", filt_log[1], 400);
      chk("midrst_ramp2", filt_log[2], 600);
    end else begin
      fail_now("midrst_no_filt");
    end
    if (beat_log.size() >= 2) begin
      chk("midrst_first_iv", int'(beat_log[0].iv), 0);
      chk("midrst_first_ibi", beat_log[0].ibi, 3);
      chk("midrst_second_ibi", beat_log[1].ibi, 100);
      chk("midrst_second_iv", int'(beat_log[1].iv), 1);
    end else begin
      fail_now("midrst_missing_beats");
    end

    // long silence saturates the interval counter
    send_n(0, 5000);
    send_n(800, 10);
    send_n(0, 10);
    drain(12000, "saturate");
    if (beat_log.size() > 0) begin
      chk("sat_ibi", beat_log[beat_log.size()-1].ibi, 4095);
      chk("sat_iv", int'(beat_log[beat_log.size()-1].iv), 0);
    end else begin
      fail_now("sat_no_beat");
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
